// File: rtl/ps2_host_pkg.sv
// Shared constants, FSM state and script-step encodings for the PS/2 host command sequencer.
package ps2_host_pkg;

  localparam logic [7:0] CMD_RESET     = 8'hFF;
  localparam logic [7:0] CMD_SET_LED   = 8'hED;
  localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RSP,
    S_WAIT_BAT,
    S_NEXT,
    S_FAIL
  } state_t;

  typedef enum logic [2:0] {
    STEP_RESET,
    STEP_BAT,
    STEP_LED_CMD,
    STEP_LED_DATA,
    STEP_TM_CMD,
    STEP_TM_DATA,
    STEP_DONE
  } step_t;

  // Full-length successor; the top trims the script after the LED data byte.
  function automatic step_t next_step(input step_t cur);
    case (cur)
      STEP_RESET:    next_step = STEP_BAT;
      STEP_BAT:      next_step = STEP_LED_CMD;
      STEP_LED_CMD:  next_step = STEP_LED_DATA;
      STEP_LED_DATA: next_step = STEP_TM_CMD;
      STEP_TM_CMD:   next_step = STEP_TM_DATA;
      default:       next_step = STEP_DONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_host_timer.sv
// Loadable down-counter for response timeouts; ms_sel=0 selects the ACK limit, 1 the BAT limit.
module ps2_host_timer #(
  parameter int unsigned CLK_FREQ = 28000000,
  parameter int unsigned ACK_MS   = 20,
  parameter int unsigned BAT_MS   = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ms_sel,
  output logic expired
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
  localparam int unsigned ACK_CYC    = CYC_PER_MS * ACK_MS;
  localparam int unsigned BAT_CYC    = CYC_PER_MS * BAT_MS;
  localparam int unsigned MAX_CYC    = (ACK_CYC > BAT_CYC) ? ACK_CYC : BAT_CYC;
  localparam int unsigned CNT_W      = $clog2(MAX_CYC + 1);

  logic [CNT_W-1:0] cnt;
  logic             run;

  // expired stays high until the next start so a late check still sees it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      run     <= 1'b0;
      expired <= 1'b0;
    end else if (start) begin
      cnt     <= ms_sel ? CNT_W'(BAT_CYC - 1) : CNT_W'(ACK_CYC - 1);
      run     <= 1'b1;
      expired <= 1'b0;
    end else if (run) begin
      if (cnt == '0) begin
        run     <= 1'b0;
        expired <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host command sequencer: keyboard reset/BAT, LED update, ACK/RESEND handling with retries.
// Build option PS2_TYPEMATIC_EN appends F3/TYPEMATIC to the init script.
module ps2_host_ctrl #(
  parameter int unsigned CLK_FREQ       = 28000000,
  parameter int unsigned ACK_TIMEOUT_MS = 20,
  parameter int unsigned BAT_TIMEOUT_MS = 1000,
  parameter int unsigned MAX_RETRY      = 3,
  parameter logic [7:0]  TYPEMATIC      = 8'h20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_state,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       tx_error,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic       rx_owned,
  output logic       busy,
  output logic       kbd_ok,
  output logic       err
);

  import ps2_host_pkg::*;

  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

`ifdef PS2_TYPEMATIC_EN
  localparam logic TM_EN = 1'b1;
`else
  localparam logic TM_EN = 1'b0;
`endif

  state_t             state_q, state_d;
  step_t              step_q, step_d, step_n_c;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               init_pend_q, init_pend_d;
  logic               led_pend_q, led_pend_d;
  logic               is_init_q, is_init_d;
  logic [7:0]         tx_data_d;
  logic               kbd_ok_d, err_d;
  logic               retry_c, start_c, bat_sel_c;
  logic               expired;

  ps2_host_timer #(
    .CLK_FREQ (CLK_FREQ),
    .ACK_MS   (ACK_TIMEOUT_MS),
    .BAT_MS   (BAT_TIMEOUT_MS)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_c),
    .ms_sel  (bat_sel_c),
    .expired (expired)
  );

  // Next-state, script stepping and registered-output next values
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    step_n_c    = step_q;
    retry_d     = retry_q;
    init_pend_d = init_pend_q;
    led_pend_d  = led_pend_q;
    is_init_d   = is_init_q;
    tx_data_d   = tx_data;
    kbd_ok_d    = kbd_ok;
    err_d       = err;
    retry_c     = 1'b0;
    start_c     = 1'b0;
    bat_sel_c   = 1'b0;

    if (init_req) init_pend_d = 1'b1;
    if (led_req)  led_pend_d  = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (init_pend_q) begin
          // init finishes with an LED update, so a pending LED request is absorbed
          init_pend_d = 1'b0;
          led_pend_d  = 1'b0;
          is_init_d   = 1'b1;
          step_d      = STEP_RESET;
          tx_data_d   = CMD_RESET;
          retry_d     = '0;
          kbd_ok_d    = 1'b0;
          err_d       = 1'b0;
          state_d     = S_SEND;
        end else if (led_pend_q) begin
          led_pend_d = 1'b0;
          is_init_d  = 1'b0;
          step_d     = STEP_LED_CMD;
          tx_data_d  = CMD_SET_LED;
          retry_d    = '0;
          err_d      = 1'b0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_error) begin
          retry_c = 1'b1;
        end else if (tx_ready) begin
          start_c = 1'b1;
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        // non-ACK/RESEND bytes are in-flight scancodes and are ignored
        if (rx_error) begin
          retry_c = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == RSP_ACK)         state_d = S_NEXT;
          else if (rx_data == RSP_RESEND) retry_c = 1'b1;
        end else if (expired) begin
          retry_c = 1'b1;
        end
      end
      S_WAIT_BAT: begin
        if (rx_valid && !rx_error) begin
          if (rx_data == RSP_BAT_OK) begin
            kbd_ok_d = 1'b1;
            state_d  = S_NEXT;
          end else if (rx_data == RSP_BAT_FAIL) begin
            kbd_ok_d = 1'b0;
            state_d  = S_FAIL;
          end
        end else if (expired) begin
          kbd_ok_d = 1'b0;
          state_d  = S_FAIL;
        end
      end
      S_NEXT: begin
        step_n_c = next_step(step_q);
        if (step_q == STEP_LED_DATA && !(TM_EN && is_init_q)) step_n_c = STEP_DONE;
        step_d  = step_n_c;
        retry_d = '0;
        case (step_n_c)
          STEP_DONE: state_d = S_IDLE;
          STEP_BAT: begin
            start_c   = 1'b1;
            bat_sel_c = 1'b1;
            state_d   = S_WAIT_BAT;
          end
          STEP_LED_DATA: begin
            tx_data_d = {5'b0, led_state};
            if (is_init_q) led_pend_d = 1'b0;
            state_d = S_SEND;
          end
          STEP_LED_CMD: begin
            tx_data_d = CMD_SET_LED;
            state_d   = S_SEND;
          end
          STEP_TM_CMD: begin
            tx_data_d = CMD_TYPEMATIC;
            state_d   = S_SEND;
          end
          STEP_TM_DATA: begin
            tx_data_d = TYPEMATIC;
            state_d   = S_SEND;
          end
          default: begin
            tx_data_d = CMD_RESET;
            state_d   = S_SEND;
          end
        endcase
      end
      S_FAIL: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // retransmit the same byte until the retry budget is spent
    if (retry_c) begin
      if (retry_q >= RETRY_W'(MAX_RETRY)) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = S_SEND;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= STEP_RESET;
      retry_q     <= '0;
      init_pend_q <= 1'b1;
      led_pend_q  <= 1'b0;
      is_init_q   <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      rx_owned    <= 1'b0;
      busy        <= 1'b0;
      kbd_ok      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      retry_q     <= retry_d;
      init_pend_q <= init_pend_d;
      led_pend_q  <= led_pend_d;
      is_init_q   <= is_init_d;
      tx_data     <= tx_data_d;
      tx_valid    <= (state_d == S_SEND);
      rx_owned    <= (state_d != S_IDLE);
      busy        <= (state_d != S_IDLE);
      kbd_ok      <= kbd_ok_d;
      err         <= err_d;
    end
  end

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
Host-side command sequencer for the PS/2 keyboard link. It drives the transmit side of the PS/2 transceiver to reset the keyboard and set its LEDs, and collects ACK, RESEND and BAT responses. While it owns the receive stream it flags those bytes, so the scancode decoder ignores them. It sits between the transceiver and the keyboard matrix decoder in the top-level keyboard path.

Parameters:
CLK_FREQ, 28000000, system clock frequency in Hz; used to derive timeouts
ACK_TIMEOUT_MS, 20, maximum wait for a response byte after a byte is sent
BAT_TIMEOUT_MS, 1000, maximum wait for BAT (0xAA) after the reset command
MAX_RETRY, 3, number of retransmissions of one byte on RESEND or timeout before giving up
TYPEMATIC, 8'h20, rate/delay byte; used only with PS2_TYPEMATIC_EN

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
init_req  in  1  single-cycle pulse: run the full keyboard init sequence
led_req  in  1  single-cycle pulse: push led_state to the keyboard
led_state  in  3  {caps, num, scroll}; sampled when the LED data byte is issued
tx_data  out  8  byte to the transceiver
tx_valid  out  1  transmit request; held until tx_ready
tx_ready  in  1  transceiver accepted tx_data (one-cycle pulse)
tx_error  in  1  transceiver reported a transmit failure (no device ACK bit)
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid (one-cycle pulse)
rx_error  in  1  receive frame or parity error (one-cycle pulse)
rx_owned  out  1  high while the controller consumes responses; decoder must drop rx_valid bytes
busy  out  1  a sequence is in progress
kbd_ok  out  1  last init completed with BAT 0xAA
err  out  1  sticky: last sequence aborted; cleared at the start of the next sequence

Behaviour:
- Reset values: tx_valid=0, tx_data=0, rx_owned=0, busy=0, kbd_ok=0, err=0. Both pending flags are cleared, then init_pend is set, so init runs automatically once reset is released.
- Requests are latched. init_req sets init_pend; led_req sets led_pend. A pulse that arrives while busy re-arms its flag; the sequence then reruns after the current one finishes and does not interrupt it.
- Arbitration in IDLE: init_pend has priority over led_pend. Starting init also clears led_pend, because init ends by sending the LEDs.
- Init script: FF -> FA -> wait AA -> ED -> FA -> {5'b0, led_state} -> FA -> done. LED script: ED -> FA -> {5'b0, led_state} -> FA -> done.
- FSM states:
  - IDLE: pick the next script.
  - SEND: assert tx_valid with the current byte; go to WAIT_RSP on tx_ready.
  - WAIT_RSP: wait for the response byte.
  - WAIT_BAT: wait for AA after reset.
  - NEXT: advance the script step.
  - FAIL: set err, go to IDLE.
- busy=1 and rx_owned=1 in every state except IDLE. rx_owned deasserts one cycle after the final FA.
- WAIT_RSP responses:
  - FA: go to NEXT.
  - FE: retry.
  - Any other byte: ignored, since it is a scancode in flight; the timeout still runs.
  - rx_error: retry.
  - Timeout (ACK_TIMEOUT_MS): retry.
  - tx_error while in SEND: retry.
- Retry: return to SEND with the same byte and increment the retry counter. If retries exceed MAX_RETRY, go to FAIL. The counter clears on each advance to a new byte.
- WAIT_BAT: AA sets kbd_ok=1 and goes to NEXT. FC, or a timeout at BAT_TIMEOUT_MS, goes to FAIL with kbd_ok=0. Other bytes are ignored. kbd_ok is cleared on entry to an init sequence.
- Timer: counts clk cycles with a limit of CLK_FREQ/1000*ms. It restarts on every SEND->WAIT transition.
- Simultaneous events: rx_valid together with timeout in the same cycle is treated as byte received. A rx_error coincident with rx_valid is treated as error.
- An asynchronous reset mid-sequence aborts immediately with all outputs at their reset values; the transceiver is responsible for releasing the bus lines.

Optional Feature:
PS2_TYPEMATIC_EN
- Defined: the init script appends F3 -> FA -> TYPEMATIC -> FA after the LED bytes, with the same retry rules. The LED script is unchanged.
- Undefined: no F3 command is ever sent, and the TYPEMATIC parameter is unused.

Decomposition:
- Package ps2_host_pkg holds:
  - command constants: RESET=FF, SET_LED=ED, TYPEMATIC=F3
  - response constants: ACK=FA, RESEND=FE, BAT_OK=AA, BAT_FAIL=FC
  - FSM state enum
  - script-step encoding
- One sub-module, ps2_host_timer: loadable down-counter with ms-to-cycles conversion, inputs start and ms_sel, output expired.

Test Plan:
- Release reset; model answers FA, then AA after 5 ms, then FA to each later byte -> tx sequence FF, ED, 00, FA-acked; kbd_ok=1, err=0, busy falls.
- led_req with led_state=3'b101 in IDLE -> tx ED, 05; rx_owned high throughout; a scancode 1C received mid-sequence is ignored and still owned.
- Model answers FE twice to ED, then FA -> ED sent 3 times and the sequence completes. With MAX_RETRY=3, FE four times -> FAIL, err=1.
- No response to FF -> FF retransmitted after each 20 ms, FAIL after 4 total sends. No AA within 1000 ms -> err=1, kbd_ok=0.
- led_req pulses during init -> no extra LED sequence. led_req during an LED sequence -> exactly one follow-up ED sequence carrying the new led_state.
- Assert rst_n low during WAIT_RSP -> all outputs at reset values within 0 cycles; after release, init restarts with FF.
